// File: rtl/spike_rate_classifier_pkg.sv
// Shared defaults and FSM state encoding for the spike-rate classifier.
package spike_rate_classifier_pkg;

    localparam int unsigned NEURONS_DEF   = 4;
    localparam int unsigned TIMESTEPS_DEF = 32;
    localparam int unsigned CNT_W_DEF     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/spike_rate_classifier_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter
    import spike_rate_classifier_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spike_rate_classifier.sv
// Counts per-neuron spikes over a window of ce-qualified timesteps, then picks the
// winning class with a one-neuron-per-cycle argmax and holds the result.
module spike_rate_classifier
    import spike_rate_classifier_pkg::*;
#(
    parameter int unsigned NEURONS   = NEURONS_DEF,
    parameter int unsigned TIMESTEPS = TIMESTEPS_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned IDX_W     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               start,
    input  logic [NEURONS-1:0] spike_in,
    output logic               busy,
    output logic               class_valid,
    output logic [IDX_W-1:0]   class_out,
    output logic [CNT_W-1:0]   max_count,
    output logic               no_spike
);

    localparam int unsigned STEP_W = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TIMESTEPS - 1);
    localparam logic [IDX_W-1:0]  SCAN_LAST = IDX_W'(NEURONS - 1);

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [IDX_W-1:0]   scan_q, scan_d;
    logic [CNT_W-1:0]   best_q, best_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   class_q, class_d;
    logic [CNT_W-1:0]   maxc_q, maxc_d;
    logic               nospk_q, nospk_d;

    logic               clr_cnt;
    logic [CNT_W-1:0]   cnt [NEURONS];
    logic [CNT_W-1:0]   cur_cnt;
    logic [CNT_W-1:0]   cand_best;
    logic [IDX_W-1:0]   cand_idx;

    for (genvar i = 0; i < NEURONS; i++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_cnt),
            .inc   ((state_q == ST_ACCUM) && ce && spike_in[i]),
            .count (cnt[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        scan_d     = scan_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        class_d    = class_q;
        maxc_d     = maxc_q;
        nospk_d    = nospk_q;
        clr_cnt    = 1'b0;
        cur_cnt    = cnt[scan_q];
        cand_best  = best_q;
        cand_idx   = best_idx_q;

        // Strict '>' keeps the earlier (lower) index on ties; slot 0 seeds the running best.
        if (scan_q == '0 || cur_cnt > best_q) begin
            cand_best = cur_cnt;
            cand_idx  = scan_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    step_d  = '0;
                    clr_cnt = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (ce) begin
                    if (step_q == STEP_LAST) begin
                        state_d = ST_SCAN;
                        scan_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                best_d     = cand_best;
                best_idx_d = cand_idx;
                if (scan_q == SCAN_LAST) begin
                    state_d = ST_DONE;
                    class_d = cand_idx;
                    maxc_d  = cand_best;
                    nospk_d = (cand_best == '0);
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d == ST_ACCUM) || (state_d == ST_SCAN);
        valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            scan_q     <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            class_q    <= '0;
            maxc_q     <= '0;
            nospk_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            scan_q     <= scan_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            class_q    <= class_d;
            maxc_q     <= maxc_d;
            nospk_q    <= nospk_d;
        end
    end

    assign busy        = busy_q;
    assign class_valid = valid_q;
    assign class_out   = class_q;
    assign max_count   = maxc_q;
    assign no_spike    = nospk_q;

endmodule

// File: tb/tb_spike_rate_classifier.sv
// Directed bench: default instance plus a CNT_W=4 instance sharing the same stimulus.
module tb_spike_rate_classifier;
    import spike_rate_classifier_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       start = 1'b0;
    logic [3:0] spike_in = '0;

    logic       busy, class_valid, no_spike;
    logic [1:0] class_out;
    logic [5:0] max_count;
    logic       busy4, class_valid4, no_spike4;
    logic [1:0] class_out4;
    logic [3:0] max_count4;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spike_rate_classifier #(.NEURONS(4), .TIMESTEPS(32), .CNT_W(6), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .spike_in(spike_in),
        .busy(busy), .class_valid(class_valid), .class_out(class_out),
        .max_count(max_count), .no_spike(no_spike)
    );

    spike_rate_classifier #(.NEURONS(4), .TIMESTEPS(32), .CNT_W(4), .IDX_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .spike_in(spike_in),
        .busy(busy4), .class_valid(class_valid4), .class_out(class_out4),
        .max_count(max_count4), .no_spike(no_spike4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pattern(input int mode, input int k);
        case (mode)
            1: return 4'b0100;
            3: return (k < 10) ? 4'b1010 : 4'b0000;
            4: return 4'b0001;
            5: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // lat: edges from start-accept to first class_valid; lat_ce: edges after the 32nd ce edge.
    task automatic run_window(input int mode, input bit poke_start, output int lat, output int lat_ce);
        int nce;
        int c32;
        lat = -1;
        lat_ce = -1;
        nce = 0;
        c32 = -1;
        @(negedge clk);
        start = 1'b1;
        ce = 1'b1;
        spike_in = pattern(mode, 0);
        @(posedge clk);
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (class_valid) begin
                lat = c - 1;
                if (c32 >= 0) lat_ce = (c - 1) - c32;
                break;
            end
            start = poke_start && (c == 10);
            ce = (mode == 4) ? (c % 3 == 0) : 1'b1;
            spike_in = pattern(mode, nce);
            if (ce) begin
                nce++;
                if (nce == 32) c32 = c;
            end
            @(posedge clk);
        end
        start = 1'b0;
        ce = 1'b0;
        spike_in = '0;
    endtask

    int lat, lat_ce;

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", class_valid, 0);
        check("rst_class", class_out, 0);
        check("rst_max", max_count, 0);
        check("rst_nospike", no_spike, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_window(1, 0, lat, lat_ce);
        check("t1_lat", lat, 36);
        check("t1_lat_ce", lat_ce, 4);
        check("t1_class", class_out, 2);
        check("t1_max", max_count, 32);
        check("t1_nospike", no_spike, 0);
        check("t1_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("t1_hold_valid", class_valid, 1);
        check("t1_hold_class", class_out, 2);

        run_window(2, 0, lat, lat_ce);
        check("t2_lat", lat, 36);
        check("t2_class", class_out, 0);
        check("t2_max", max_count, 0);
        check("t2_nospike", no_spike, 1);

        run_window(3, 0, lat, lat_ce);
        check("t3_class", class_out, 1);
        check("t3_max", max_count, 10);
        check("t3_nospike", no_spike, 0);

        run_window(4, 0, lat, lat_ce);
        check("t4_lat", lat, 100);
        check("t4_lat_ce", lat_ce, 4);
        check("t4_class", class_out, 0);
        check("t4_max", max_count, 32);

        run_window(5, 0, lat, lat_ce);
        check("t5_class", class_out, 3);
        check("t5_max", max_count, 32);
        check("t5_valid4", class_valid4, 1);
        check("t5_class4", class_out4, 3);
        check("t5_max4", max_count4, 15);

        run_window(1, 1, lat, lat_ce);
        check("t6_ignore_start_lat", lat, 36);
        check("t6_ignore_start_max", max_count, 32);

        // Restart from DONE, then reset once the scan is under way.
        @(negedge clk);
        start = 1'b1;
        ce = 1'b1;
        @(posedge clk);
        #1;
        check("t6_restart_valid", class_valid, 0);
        check("t6_restart_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (33) @(posedge clk);
        @(negedge clk);
        check("t6_scan_busy", busy, 1);
        check("t6_scan_valid", class_valid, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", class_valid, 0);
        check("t6_rst_class", class_out, 0);
        check("t6_rst_max", max_count, 0);
        check("t6_rst_nospike", no_spike, 0);
        ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_rst_hold_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_valid", class_valid, 0);

        run_window(3, 0, lat, lat_ce);
        check("t6_after_rst_lat", lat, 36);
        check("t6_after_rst_class", class_out, 1);
        check("t6_after_rst_max", max_count, 10);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
